// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, keeps up to DEPTH word fetches in flight and
// buffers returned instructions for decode. A redirect flushes all wrong-path work.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_IF_pause,
  input  logic        i_IF_brTaken,
  input  logic [31:0] i_IF_brTarget,
  output logic        o_IF_iMemReq,
  output logic [31:0] o_IF_iMemAddr,
  input  logic        i_IF_iMemGnt,
  input  logic        i_IF_iMemRValid,
  input  logic [31:0] i_IF_iMemRData,
  output logic        o_IF_valid,
  output logic [31:0] o_IF_PC,
  output logic [31:0] o_IF_inst
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [CW:0] DepthW = DEPTH[CW:0];

  logic [31:0] pc_q;
  cnt_t        out_q, out_d;
  cnt_t        drop_q;

  // Issued-address queue: PCs of fetches whose response is still owed to the FIFO.
  logic [31:0] iq_q [DEPTH];
  ptr_t        iq_rd_q, iq_wr_q;

  // Presentation FIFO of {PC, instruction}.
  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] fifo_inst_q [DEPTH];
  ptr_t        fifo_rd_q, fifo_wr_q;
  cnt_t        fifo_cnt_q, fifo_cnt_d;

  // Last presented entry, shown while the FIFO is empty.
  logic [31:0] held_pc_q, held_inst_q;

  logic credit_ok;
  logic fire;
  logic resp;
  logic resp_keep;
  logic resp_drop;
  logic fifo_valid;
  logic pop;

  always_comb begin
    credit_ok  = ({1'b0, out_q} + {1'b0, fifo_cnt_q}) < DepthW;
    fire       = o_IF_iMemReq && i_IF_iMemGnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp       = i_IF_iMemRValid && (out_q != '0);
    resp_keep  = resp && (drop_q == '0) && !i_IF_brTaken;
    resp_drop  = resp && (drop_q != '0) && !i_IF_brTaken;
    fifo_valid = fifo_cnt_q != '0;
    pop        = fifo_valid && !i_IF_pause;
    out_d      = out_q + cnt_t'(fire) - cnt_t'(resp);
    fifo_cnt_d = fifo_cnt_q + cnt_t'(resp_keep) - cnt_t'(pop);
  end

  assign o_IF_iMemReq  = !rst && !i_IF_brTaken && credit_ok;
  assign o_IF_iMemAddr = pc_q;
  assign o_IF_valid    = fifo_valid;
  assign o_IF_PC       = fifo_valid ? fifo_pc_q[fifo_rd_q]   : held_pc_q;
  assign o_IF_inst     = fifo_valid ? fifo_inst_q[fifo_rd_q] : held_inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      out_q       <= '0;
      drop_q      <= '0;
      iq_rd_q     <= '0;
      iq_wr_q     <= '0;
      fifo_rd_q   <= '0;
      fifo_wr_q   <= '0;
      fifo_cnt_q  <= '0;
      held_pc_q   <= '0;
      held_inst_q <= '0;
    end else begin
      out_q <= out_d;
      if (i_IF_brTaken) begin
        // Everything still pending after this edge belongs to the wrong path.
        pc_q       <= i_IF_brTarget;
        drop_q     <= out_d;
        iq_rd_q    <= '0;
        iq_wr_q    <= '0;
        fifo_rd_q  <= '0;
        fifo_wr_q  <= '0;
        fifo_cnt_q <= '0;
      end else begin
        if (fire) begin
          pc_q    <= pc_q + 32'd4;
          iq_wr_q <= iq_wr_q + ptr_t'(1);
        end
        if (resp_keep) begin
          iq_rd_q   <= iq_rd_q + ptr_t'(1);
          fifo_wr_q <= fifo_wr_q + ptr_t'(1);
        end
        if (resp_drop) begin
          drop_q <= drop_q - cnt_t'(1);
        end
        if (pop) begin
          fifo_rd_q <= fifo_rd_q + ptr_t'(1);
        end
        fifo_cnt_q <= fifo_cnt_d;
      end
      if (fifo_valid) begin
        held_pc_q   <= fifo_pc_q[fifo_rd_q];
        held_inst_q <= fifo_inst_q[fifo_rd_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      iq_q[iq_wr_q] <= pc_q;
    end
    if (resp_keep && !rst) begin
      fifo_pc_q[fifo_wr_q]   <= iq_q[iq_rd_q];
      fifo_inst_q[fifo_wr_q] <= i_IF_iMemRData;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a behavioural in-order instruction memory, a cycle table for the
// streaming/pause case, directed redirect/reset/wrap sequences and a randomised stream check.
module tb_inst_fetch;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        pause;
  logic        br_taken;
  logic [31:0] br_target;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_IF_pause      (pause),
    .i_IF_brTaken    (br_taken),
    .i_IF_brTarget   (br_target),
    .o_IF_iMemReq    (req),
    .o_IF_iMemAddr   (addr),
    .i_IF_iMemGnt    (gnt),
    .i_IF_iMemRValid (rvalid),
    .i_IF_iMemRData  (rdata),
    .o_IF_valid      (valid),
    .o_IF_PC         (pc),
    .o_IF_inst       (inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  pend_t       memq[$];
  int unsigned cyc      = 0;
  int unsigned last_due = 0;
  int unsigned lat      = 1;
  bit          rand_lat = 1'b0;
  bit          rand_gnt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic p, input logic b, input logic [31:0] t);
    pause     = p;
    br_taken  = b;
    br_target = t;
    #1;
  endtask

  // Advance one clock; the memory model then drives grant/response for the new cycle.
  task automatic step();
    logic        s_fire;
    logic        s_rv;
    logic [31:0] s_addr;
    int unsigned due;
    s_fire = req && gnt;
    s_rv   = rvalid;
    s_addr = addr;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      memq.delete();
      last_due = cyc;
    end else begin
      if (s_rv && memq.size() > 0) void'(memq.pop_front());
      if (s_fire) begin
        due = cyc - 1 + (rand_lat ? $urandom_range(1, 4) : lat);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        memq.push_back('{addr: s_addr, due: due});
      end
    end
    rvalid = (memq.size() > 0) && (memq[0].due <= cyc);
    rdata  = rvalid ? (memq[0].addr ^ KEY) : 32'h0;
    gnt    = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_valid: got no valid instruction within 60 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic expect_head(input string name, input logic [31:0] exp_pc);
    chk({name, "_pc"}, pc, exp_pc);
    chk({name, "_inst"}, inst, exp_pc ^ KEY);
  endtask

  typedef struct {
    logic        pause;
    logic        valid;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[17];

  initial begin : main
    logic [31:0] exp_pc;
    logic [31:0] prev_pc;
    logic [31:0] exp_inst;
    logic [31:0] t;
    bit          seen_valid;
    bit          prev_hold;
    bit          p;
    bit          b;
    int unsigned pops;

    // Grant every cycle, 1-cycle latency; 5-cycle pause starting when PC 0x10 is presented.
    vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
    vecs[2]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h08};
    vecs[3]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h08};
    vecs[4]  = '{1'b0, 1'b0, 32'h04, 1'b1, 32'h0C};
    vecs[5]  = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h10};
    vecs[6]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h10};
    vecs[7]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h14};
    vecs[8]  = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h18};
    vecs[9]  = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h18};
    vecs[10] = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h18};
    vecs[11] = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h18};
    vecs[12] = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h18};
    vecs[13] = '{1'b0, 1'b1, 32'h10, 1'b0, 32'h18};
    vecs[14] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h18};
    vecs[15] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h1C};
    vecs[16] = '{1'b0, 1'b1, 32'h18, 1'b0, 32'h20};

    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    drive(1'b0, 1'b0, 32'h0);
    step();
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    step();
    rst = 1'b0;

    seen_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].pause, 1'b0, 32'h0);
      if (vecs[i].valid) seen_valid = 1'b1;
      exp_inst = seen_valid ? (vecs[i].pc ^ KEY) : 32'h0;
      chk($sformatf("tab%0d_valid", i + 1), 32'(valid), 32'(vecs[i].valid));
      chk($sformatf("tab%0d_pc", i + 1), pc, vecs[i].pc);
      chk($sformatf("tab%0d_inst", i + 1), inst, exp_inst);
      chk($sformatf("tab%0d_req", i + 1), 32'(req), 32'(vecs[i].req));
      chk($sformatf("tab%0d_addr", i + 1), addr, vecs[i].addr);
      step();
    end

    // Redirect with two fetches in flight, 3-cycle latency.
    lat = 3;
    do_reset();
    drive(1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 32'h100);
    chk("redir_req_low", 32'(req), 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0);
    chk("redir_valid_low", 32'(valid), 32'h0);
    chk("redir_addr", addr, 32'h100);
    step();
    wait_valid();
    expect_head("redir_first", 32'h100);
    step();
    drive(1'b0, 1'b0, 32'h0);
    chk("redir_second_valid", 32'(valid), 32'h1);
    expect_head("redir_second", 32'h104);
    step();

    // Redirect in the same cycle as a response and a held-high grant.
    lat = 2;
    do_reset();
    drive(1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 32'h200);
    chk("same_rvalid_seen", 32'(rvalid && gnt), 32'h1);
    chk("same_req_low", 32'(req), 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0);
    chk("same_valid_low", 32'(valid), 32'h0);
    chk("same_req", 32'(req), 32'h1);
    chk("same_addr", addr, 32'h200);
    step();
    wait_valid();
    expect_head("same_first", 32'h200);
    step();
    wait_valid();
    expect_head("same_second", 32'h204);
    step();

    // Back-to-back redirects: the later target wins.
    drive(1'b0, 1'b1, 32'h300); step();
    drive(1'b0, 1'b1, 32'h400); step();
    wait_valid();
    expect_head("b2b_first", 32'h400);
    step();
    wait_valid();
    expect_head("b2b_second", 32'h404);
    step();

    // PC wraps from the top of the address space.
    lat = 1;
    drive(1'b0, 1'b1, 32'hFFFF_FFF8); step();
    wait_valid(); expect_head("wrap_a", 32'hFFFF_FFF8); step();
    wait_valid(); expect_head("wrap_b", 32'hFFFF_FFFC); step();
    wait_valid(); expect_head("wrap_c", 32'h0000_0000); step();

    // Reset with fetches in flight.
    drive(1'b0, 1'b0, 32'h0); step();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    step();
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_req", 32'(req), 32'h0);
    chk("mid_rst_addr", addr, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_inst", inst, 32'h0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    chk("restart_req", 32'(req), 32'h1);
    chk("restart_addr", addr, 32'h0);
    wait_valid();
    expect_head("restart_first", 32'h0);
    step();

    // Random grant, latency 1-4, pause and redirects against a reference PC stream.
    rand_gnt = 1'b1;
    rand_lat = 1'b1;
    do_reset();
    exp_pc    = 32'h0;
    prev_hold = 1'b0;
    prev_pc   = 32'h0;
    pops      = 0;
    for (int i = 0; i < 3000; i++) begin
      p = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 39) == 0);
      t = 32'($urandom_range(0, 1023)) << 2;
      drive(p, b, t);
      chk("inv_credit", 32'((32'(dut.out_q) + 32'(dut.fifo_cnt_q)) <= DEPTH), 32'h1);
      chk("inv_drop", 32'(dut.drop_q <= dut.out_q), 32'h1);
      if (prev_hold) begin
        chk("rand_pause_valid", 32'(valid), 32'h1);
        chk("rand_pause_pc", pc, prev_pc);
      end
      if (valid && !p && !b) begin
        expect_head("rand_stream", exp_pc);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (b) exp_pc = t;
      prev_hold = valid && p && !b;
      prev_pc   = pc;
      step();
    end
    chk("rand_progress", 32'(pops > 300), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
